// File: rtl/writeback_stage.sv
// Final pipeline stage: buffers execute results in a small FIFO and commits them
// in order to the register-file write port, the 16 output ports, or the status flags.
module writeback_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [DATA_W-1:0]        ex_sum,
    input  logic [DATA_W-1:0]        ex_carry,
    input  logic [ADDR_W-1:0]        ex_dest,
    input  logic [1:0]               ex_kind,
    input  logic                     rf_busy,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [DATA_W-1:0]        port_out_00,
    output logic [DATA_W-1:0]        port_out_01,
    output logic [DATA_W-1:0]        port_out_02,
    output logic [DATA_W-1:0]        port_out_03,
    output logic [DATA_W-1:0]        port_out_04,
    output logic [DATA_W-1:0]        port_out_05,
    output logic [DATA_W-1:0]        port_out_06,
    output logic [DATA_W-1:0]        port_out_07,
    output logic [DATA_W-1:0]        port_out_08,
    output logic [DATA_W-1:0]        port_out_09,
    output logic [DATA_W-1:0]        port_out_10,
    output logic [DATA_W-1:0]        port_out_11,
    output logic [DATA_W-1:0]        port_out_12,
    output logic [DATA_W-1:0]        port_out_13,
    output logic [DATA_W-1:0]        port_out_14,
    output logic [DATA_W-1:0]        port_out_15,
    output logic                     flag_carry,
    output logic                     flag_zero,
    output logic [$clog2(DEPTH):0]   wb_count
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int NPORT = 16;

    localparam logic [1:0] KIND_REG  = 2'b00;
    localparam logic [1:0] KIND_PORT = 2'b01;
    localparam logic [1:0] KIND_FLAG = 2'b10;

    typedef enum logic {HOLD, RUN} state_t;

    state_t            state_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic [DATA_W-1:0] mem_sum   [DEPTH];
    logic              mem_carry [DEPTH];
    logic [ADDR_W-1:0] mem_dest  [DEPTH];
    logic [1:0]        mem_kind  [DEPTH];

    logic [DATA_W-1:0] port_reg [NPORT];
    logic              rf_we_reg;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic              flag_carry_reg;
    logic              flag_zero_reg;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_sum;
    logic              head_carry;
    logic [ADDR_W-1:0] head_dest;
    logic [1:0]        head_kind;
    logic              carry_lsbs_unused;

    // Only the top bit of carry_out is the architectural carry.
    assign carry_lsbs_unused = ^ex_carry[DATA_W-2:0];

    // Ready depends only on registered state, never on this cycle's pop.
    assign ex_ready = (state_reg == RUN) && (count_reg != CW'(DEPTH));
    assign push     = ex_valid && ex_ready && !flush;
    assign pop      = (count_reg != '0) && !rf_busy && !flush;

    assign head_sum   = mem_sum[rd_ptr_reg];
    assign head_carry = mem_carry[rd_ptr_reg];
    assign head_dest  = mem_dest[rd_ptr_reg];
    assign head_kind  = mem_kind[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum[wr_ptr_reg]   <= ex_sum;
            mem_carry[wr_ptr_reg] <= ex_carry[DATA_W-1];
            mem_dest[wr_ptr_reg]  <= ex_dest;
            mem_kind[wr_ptr_reg]  <= ex_kind;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= HOLD;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= RUN;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
            flag_carry_reg <= 1'b0;
            flag_zero_reg  <= 1'b0;
            for (int i = 0; i < NPORT; i++) port_reg[i] <= '0;
        end else begin
            rf_we_reg <= pop && (head_kind == KIND_REG);
            if (pop) begin
                if (head_kind == KIND_REG) begin
                    rf_waddr_reg <= head_dest;
                    rf_wdata_reg <= head_sum;
                end
                if (head_kind == KIND_PORT) port_reg[head_dest] <= head_sum;
                if (head_kind == KIND_REG || head_kind == KIND_PORT || head_kind == KIND_FLAG) begin
                    flag_carry_reg <= head_carry;
                    flag_zero_reg  <= (head_sum == '0);
                end
            end
        end
    end

    assign rf_we      = rf_we_reg;
    assign rf_waddr   = rf_waddr_reg;
    assign rf_wdata   = rf_wdata_reg;
    assign flag_carry = flag_carry_reg;
    assign flag_zero  = flag_zero_reg;
    assign wb_count   = count_reg;

    assign port_out_00 = port_reg[0];
    assign port_out_01 = port_reg[1];
    assign port_out_02 = port_reg[2];
    assign port_out_03 = port_reg[3];
    assign port_out_04 = port_reg[4];
    assign port_out_05 = port_reg[5];
    assign port_out_06 = port_reg[6];
    assign port_out_07 = port_reg[7];
    assign port_out_08 = port_reg[8];
    assign port_out_09 = port_reg[9];
    assign port_out_10 = port_reg[10];
    assign port_out_11 = port_reg[11];
    assign port_out_12 = port_reg[12];
    assign port_out_13 = port_reg[13];
    assign port_out_14 = port_reg[14];
    assign port_out_15 = port_reg[15];
endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: reset, commits by kind,
// backpressure, wrap with toggling busy, flush and reset mid-drain.
module tb_writeback_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       ex_valid;
    logic       ex_ready;
    logic [7:0] ex_sum;
    logic [7:0] ex_carry;
    logic [3:0] ex_dest;
    logic [1:0] ex_kind;
    logic       rf_busy;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] port_out [16];
    logic       flag_carry;
    logic       flag_zero;
    logic [2:0] wb_count;

    int n_checks = 0;
    int n_fails  = 0;

    writeback_stage #(.DATA_W(8), .ADDR_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_sum(ex_sum), .ex_carry(ex_carry), .ex_dest(ex_dest), .ex_kind(ex_kind),
        .rf_busy(rf_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .port_out_00(port_out[0]),  .port_out_01(port_out[1]),
        .port_out_02(port_out[2]),  .port_out_03(port_out[3]),
        .port_out_04(port_out[4]),  .port_out_05(port_out[5]),
        .port_out_06(port_out[6]),  .port_out_07(port_out[7]),
        .port_out_08(port_out[8]),  .port_out_09(port_out[9]),
        .port_out_10(port_out[10]), .port_out_11(port_out[11]),
        .port_out_12(port_out[12]), .port_out_13(port_out[13]),
        .port_out_14(port_out[14]), .port_out_15(port_out[15]),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] c,
                         input logic [3:0] d, input logic [1:0] k);
        ex_valid = v;
        ex_sum   = s;
        ex_carry = c;
        ex_dest  = d;
        ex_kind  = k;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got, mc, cyc;
        logic exp_ready, acc, popm;

        // Reset held with a valid input present
        rst = 1'b0; flush = 1'b0; rf_busy = 1'b0;
        drive(1'b1, 8'hAA, 8'h80, 4'h3, 2'b00);
        tick(); tick();
        chk("rst_ready", ex_ready, 0);
        chk("rst_count", wb_count, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_carry", flag_carry, 0);
        chk("rst_zero", flag_zero, 0);
        for (int i = 0; i < 16; i++) chk("rst_port", port_out[i], 0);

        // Release: ready one edge later
        ex_valid = 1'b0;
        rst = 1'b1;
        chk("hold_ready", ex_ready, 0);
        tick();
        chk("run_ready", ex_ready, 1);

        // Register write
        drive(1'b1, 8'h3C, 8'h80, 4'd5, 2'b00);
        tick();
        chk("rw_count", wb_count, 1);
        chk("rw_we_early", rf_we, 0);
        ex_valid = 1'b0;
        tick();
        chk("rw_we", rf_we, 1);
        chk("rw_waddr", rf_waddr, 5);
        chk("rw_wdata", rf_wdata, 8'h3C);
        chk("rw_carry", flag_carry, 1);
        chk("rw_zero", flag_zero, 0);
        chk("rw_count0", wb_count, 0);
        tick();
        chk("rw_we_off", rf_we, 0);

        // Port writes and nop
        drive(1'b1, 8'hA5, 8'h00, 4'd15, 2'b01);
        tick();
        drive(1'b1, 8'h00, 8'h00, 4'd15, 2'b01);
        tick();
        chk("pw_port15a", port_out[15], 8'hA5);
        chk("pw_zero_a", flag_zero, 0);
        chk("pw_carry_a", flag_carry, 0);
        chk("pw_we", rf_we, 0);
        drive(1'b1, 8'hFF, 8'h80, 4'd0, 2'b11);
        tick();
        chk("pw_port15b", port_out[15], 8'h00);
        chk("pw_zero_b", flag_zero, 1);
        ex_valid = 1'b0;
        tick();
        chk("nop_zero", flag_zero, 1);
        chk("nop_carry", flag_carry, 0);
        chk("nop_port0", port_out[0], 0);
        chk("nop_port15", port_out[15], 0);
        chk("nop_count", wb_count, 0);
        chk("nop_waddr", rf_waddr, 5);
        chk("nop_wdata", rf_wdata, 8'h3C);

        // Backpressure fills the FIFO
        rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 8'h00, 4'(i), 2'b00);
            tick();
            chk("bp_count", wb_count, i);
        end
        chk("bp_ready", ex_ready, 0);
        drive(1'b1, 8'h05, 8'h00, 4'd5, 2'b00);
        tick();
        chk("bp_5th", wb_count, 4);
        ex_valid = 1'b0;
        rf_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bp_we", rf_we, 1);
            chk("bp_wdata", rf_wdata, 8'(i));
            chk("bp_count_dn", wb_count, 4 - i);
        end
        chk("bp_ready_back", ex_ready, 1);
        tick();
        chk("bp_we_off", rf_we, 0);

        // Stream of 10 with busy toggling; model tracks occupancy
        sent = 0; got = 0; mc = 0; cyc = 0;
        while ((sent < 10 || got < 10) && cyc < 80) begin
            rf_busy = (cyc % 2 == 1);
            if (sent < 10) drive(1'b1, 8'(16 + sent), 8'h00, 4'(sent), 2'b00);
            else ex_valid = 1'b0;
            exp_ready = (mc != 4);
            chk("st_ready", ex_ready, exp_ready);
            acc  = ex_valid && exp_ready;
            popm = (mc != 0) && !rf_busy;
            tick();
            if (acc) sent++;
            mc = mc + int'(acc) - int'(popm);
            if (rf_we) begin
                chk("st_wdata", rf_wdata, 8'(16 + got));
                got++;
            end
            chk("st_count", wb_count, mc);
            cyc++;
        end
        chk("st_all", got, 10);
        rf_busy = 1'b0;
        ex_valid = 1'b0;

        // Flags-only entry
        drive(1'b1, 8'h00, 8'h80, 4'd9, 2'b10);
        tick();
        ex_valid = 1'b0;
        tick();
        chk("fl_carry", flag_carry, 1);
        chk("fl_zero", flag_zero, 1);
        chk("fl_we", rf_we, 0);
        chk("fl_wdata", rf_wdata, 8'h19);
        chk("fl_port9", port_out[9], 0);

        // Flush mid-drain with concurrent valid
        rf_busy = 1'b1;
        drive(1'b1, 8'h31, 8'h00, 4'd1, 2'b00); tick();
        drive(1'b1, 8'h77, 8'h00, 4'd3, 2'b01); tick();
        drive(1'b1, 8'h33, 8'h00, 4'd2, 2'b00); tick();
        chk("fs_count3", wb_count, 3);
        flush = 1'b1;
        drive(1'b1, 8'h44, 8'h00, 4'd4, 2'b00);
        tick();
        chk("fs_count0", wb_count, 0);
        chk("fs_we", rf_we, 0);
        flush = 1'b0; ex_valid = 1'b0; rf_busy = 1'b0;
        tick();
        chk("fs_we2", rf_we, 0);
        chk("fs_count", wb_count, 0);
        chk("fs_port3", port_out[3], 0);
        chk("fs_wdata", rf_wdata, 8'h19);
        chk("fs_carry", flag_carry, 1);
        chk("fs_zero", flag_zero, 1);
        tick();
        chk("fs_we3", rf_we, 0);

        // Reset mid-drain
        drive(1'b1, 8'h5A, 8'h80, 4'd7, 2'b01);
        tick();
        ex_valid = 1'b0;
        tick();
        chk("rm_port7", port_out[7], 8'h5A);
        rf_busy = 1'b1;
        drive(1'b1, 8'h12, 8'h00, 4'd1, 2'b00); tick();
        drive(1'b1, 8'h13, 8'h00, 4'd2, 2'b00); tick();
        chk("rm_count2", wb_count, 2);
        rst = 1'b0;
        #1;
        chk("rm_count", wb_count, 0);
        chk("rm_port7_0", port_out[7], 0);
        chk("rm_carry", flag_carry, 0);
        chk("rm_zero", flag_zero, 0);
        chk("rm_waddr", rf_waddr, 0);
        chk("rm_wdata", rf_wdata, 0);
        chk("rm_ready", ex_ready, 0);
        tick();
        rst = 1'b1; rf_busy = 1'b0;
        drive(1'b1, 8'h66, 8'h00, 4'd2, 2'b00);
        tick();
        chk("rr_first_edge", wb_count, 0);
        chk("rr_ready", ex_ready, 1);
        tick();
        chk("rr_accept", wb_count, 1);
        ex_valid = 1'b0;
        tick();
        chk("rr_we", rf_we, 1);
        chk("rr_wdata", rf_wdata, 8'h66);
        chk("rr_waddr", rf_waddr, 2);
        tick();
        chk("rr_lost_we", rf_we, 0);
        chk("rr_lost_cnt", wb_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
